// File: rtl/wishbone_line_memory.sv
// ============================================================================
// Module      : wishbone_line_memory
// Description : Wishbone responder serving 128-bit line reads/writes from an
//               internal array after LATENCY cycles; optional out-of-range
//               ERR response enabled by macro WB_LINE_MEM_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wishbone_line_memory #(
  parameter int ADDR_W  = 12,
  parameter int INDEX_W = 8,
  parameter int LATENCY = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                CYC,
  input  logic                STB,
  input  logic                WE,
  input  logic [15:0]         SEL,
  input  logic [ADDR_W-1:0]   ADR,
  input  logic [127:0]        DAT_M,
  output logic [127:0]        DAT_S,
  output logic                ACK,
  output logic                ERR
);

  localparam int        c_DEPTH = 2**INDEX_W;
  localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_fire;
  logic                 w_req;
  logic                 w_cap;
  logic [3:0]           r_cnt;
  logic [INDEX_W-1:0]   r_idx;
  logic                 r_we;
  logic [15:0]          r_sel;
  logic [127:0]         r_dat;
  logic                 r_oor;
  logic                 w_oor_in;
  logic [INDEX_W-1:0]   w_idx;
  logic                 w_we;
  logic [15:0]          w_sel;
  logic [127:0]         w_dat;
  logic                 w_oor;
  logic [127:0]         r_mem [c_DEPTH];

  assign w_req = CYC & STB;
  assign w_cap = (r_state == S_IDLE);

`ifdef WB_LINE_MEM_ERR_EN
  assign w_oor_in = |ADR[ADDR_W-1:INDEX_W];
`else
  logic w_unused_upper;
  assign w_oor_in       = 1'b0;
  assign w_unused_upper = ^ADR[ADDR_W-1:INDEX_W];
`endif

  // With LATENCY=1 the access happens on the capture edge, so use the live bus.
  assign w_idx = w_cap ? ADR[INDEX_W-1:0] : r_idx;
  assign w_we  = w_cap ? WE       : r_we;
  assign w_sel = w_cap ? SEL      : r_sel;
  assign w_dat = w_cap ? DAT_M    : r_dat;
  assign w_oor = w_cap ? w_oor_in : r_oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (LATENCY == 1) begin
            w_next = S_RESP;
            w_fire = 1'b1;
          end else begin
            w_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (!CYC) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next = S_RESP;
          w_fire = 1'b1;
        end
      end
      S_RESP:  w_next = S_TURN;
      S_TURN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
      r_idx <= '0;
      r_we  <= 1'b0;
      r_sel <= 16'h0;
      r_dat <= 128'h0;
      r_oor <= 1'b0;
      DAT_S <= 128'h0;
      ACK   <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      if (w_cap && w_req) begin
        r_cnt <= c_CNT_LOAD;
        r_idx <= ADR[INDEX_W-1:0];
        r_we  <= WE;
        r_sel <= SEL;
        r_dat <= DAT_M;
        r_oor <= w_oor_in;
      end else if (r_state == S_BUSY && CYC) begin
        r_cnt <= r_cnt - 4'd1;
      end
      ACK <= w_fire & ~w_oor;
      ERR <= w_fire & w_oor;
      if (w_fire && !w_we && !w_oor) DAT_S <= r_mem[w_idx];
    end
  end

  // Storage is deliberately not reset; gating with rst_n drops writes under reset.
  always_ff @(posedge clk) begin
    if (w_fire && w_we && !w_oor && rst_n) begin
      for (int i = 0; i < 16; i++) begin
        if (w_sel[i]) r_mem[w_idx][8*i +: 8] <= w_dat[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wishbone_line_memory.sv
// ============================================================================
// Module      : tb_wishbone_line_memory
// Description : Directed self-checking bench with an expected-response queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wishbone_line_memory;

  localparam int LAT = 3;

  typedef struct {
    bit           is_err;
    bit           is_read;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         CYC = 1'b0, STB = 1'b0, WE = 1'b0;
  logic [15:0]  SEL = 16'h0;
  logic [11:0]  ADR = 12'h0;
  logic [127:0] DAT_M = 128'h0;
  logic [127:0] DAT_S;
  logic         ACK, ERR;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  logic [127:0] model [int];

  wishbone_line_memory #(.ADDR_W(12), .INDEX_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .CYC(CYC), .STB(STB), .WE(WE), .SEL(SEL),
    .ADR(ADR), .DAT_M(DAT_M), .DAT_S(DAT_S), .ACK(ACK), .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit oor(input logic [11:0] a);
`ifdef WB_LINE_MEM_ERR_EN
    return |a[11:8];
`else
    return 1'b0;
`endif
  endfunction

  // Drive the request and record what the responder owes for it.
  task automatic drive(input bit we, input logic [15:0] sel, input logic [11:0] adr,
                       input logic [127:0] dat);
    exp_t e;
    logic [127:0] line;
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = we; SEL = sel; ADR = adr; DAT_M = dat;
    e.is_err  = oor(adr);
    e.is_read = !we;
    e.data    = model.exists(int'(adr[7:0])) ? model[int'(adr[7:0])] : 128'h0;
    if (we && !e.is_err) begin
      line = e.data;
      for (int i = 0; i < 16; i++) if (sel[i]) line[8*i +: 8] = dat[8*i +: 8];
      model[int'(adr[7:0])] = line;
    end
    exp_q.push_back(e);
  endtask

  task automatic compare_resp(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 128'(1), 128'(0));
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_ack"}, 128'(ACK), 128'(!e.is_err));
    check({tag, "_err"}, 128'(ERR), 128'(e.is_err));
    if (e.is_read && !e.is_err) check({tag, "_data"}, DAT_S, e.data);
  endtask

  task automatic req(input string tag, input bit we, input logic [15:0] sel,
                     input logic [11:0] adr, input logic [127:0] dat);
    int seen;
    drive(we, sel, adr, dat);
    seen = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ACK || ERR) begin seen = k; break; end
    end
    check({tag, "_latency"}, 128'(seen), 128'(LAT));
    if (seen > 0) compare_resp(tag);
    else void'(exp_q.pop_front());
    CYC = 1'b0; STB = 1'b0;
    @(posedge clk); #1;
    check({tag, "_turn_quiet"}, 128'({ACK, ERR}), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int acks;
    int mask;
    logic [127:0] d_a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    logic [127:0] d_old = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC;
    logic [127:0] d_alias = 128'hDEAD_0000_1111_2222_3333_4444_5555_0105;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst_ack", 128'(ACK), 128'(0));
    check("rst_err", 128'(ERR), 128'(0));
    check("rst_dat", DAT_S, 128'h0);

    // CYC without STB must stay silent
    CYC = 1'b1; acks = 0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (ACK || ERR) acks++; end
    CYC = 1'b0;
    check("no_stb_quiet", 128'(acks), 128'(0));

    // Full write then read back
    req("wr_full", 1'b1, 16'hFFFF, 12'h005, d_a);
    req("rd_full", 1'b0, 16'hFFFF, 12'h005, 128'h0);
    check("rd_full_const", DAT_S, d_a);

    // Partial write on an all-AA line
    req("wr_aa", 1'b1, 16'hFFFF, 12'h020, {16{8'hAA}});
    req("wr_part", 1'b1, 16'h0003, 12'h020, 128'h1111_2222_3333_4444_5555_6666_7777_BEEF);
    req("rd_part", 1'b0, 16'h0000, 12'h020, 128'h0);
    check("rd_part_const", DAT_S, {{14{8'hAA}}, 16'hBEEF});

    // SEL=0 is an acknowledged no-op
    req("wr_sel0", 1'b1, 16'h0000, 12'h005, ~d_a);
    req("rd_sel0", 1'b0, 16'h0000, 12'h005, 128'h0);
    check("rd_sel0_const", DAT_S, d_a);

    // Held STB across ten edges: two accesses, ACKs at LAT and 2*LAT+2
    drive(1'b0, 16'h0, 12'h005, 128'h0);
    drive_dup: begin
      exp_t e2;
      e2 = exp_q[exp_q.size()-1];
      exp_q.push_back(e2);
    end
    mask = 0; acks = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ACK || ERR) begin
        mask |= (1 << k);
        if (k <= 5) acks++;
        compare_resp("held");
      end
    end
    CYC = 1'b0; STB = 1'b0;
    check("held_first5", 128'(acks), 128'(1));
    check("held_mask", 128'(mask), 128'((1 << LAT) | (1 << (2*LAT + 2))));
    @(posedge clk); #1;

    // Abort: drop CYC in the first BUSY cycle
    req("wr_old", 1'b1, 16'hFFFF, 12'h010, d_old);
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; SEL = 16'hFFFF; ADR = 12'h010; DAT_M = ~d_old;
    @(posedge clk); #1;
    CYC = 1'b0; STB = 1'b0;
    acks = 0;
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1; if (ACK || ERR) acks++; end
    check("abort_quiet", 128'(acks), 128'(0));
    req("rd_abort", 1'b0, 16'h0, 12'h010, 128'h0);
    check("rd_abort_const", DAT_S, d_old);

    // Upper address bits: alias by default, ERR with the macro
    req("wr_alias", 1'b1, 16'hFFFF, 12'h105, d_alias);
    req("rd_alias", 1'b0, 16'h0, 12'h005, 128'h0);
`ifdef WB_LINE_MEM_ERR_EN
    check("rd_alias_const", DAT_S, d_a);
`else
    check("rd_alias_const", DAT_S, d_alias);
`endif

    // Reset in the middle of a write discards it and clears outputs
    req("wr_pre", 1'b1, 16'hFFFF, 12'h030, d_old);
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; SEL = 16'hFFFF; ADR = 12'h030; DAT_M = d_a;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check("midrst_ack", 128'({ACK, ERR}), 128'(0));
    check("midrst_dat", DAT_S, 128'h0);
    CYC = 1'b0; STB = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    req("rd_midrst", 1'b0, 16'h0, 12'h030, 128'h0);
    check("rd_midrst_const", DAT_S, d_old);

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
